// File: rtl/pt_check_pkg.sv
// Shared types and defaults for the plaintext printable-check block.
package pt_check_pkg;

  localparam logic [7:0] CHAR_LO_DEF = 8'h20;
  localparam logic [7:0] CHAR_HI_DEF = 8'h7E;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH_LEN = 2'd1,
    LEN       = 2'd2,
    SCAN      = 2'd3
  } state_t;

endpackage

// File: rtl/pt_is_printable.sv
// Combinational printable-range test on one byte (unsigned, inclusive bounds).
module pt_is_printable
  import pt_check_pkg::*;
#(
  parameter logic [7:0] CHAR_LO = CHAR_LO_DEF,
  parameter logic [7:0] CHAR_HI = CHAR_HI_DEF
) (
  input  logic [7:0] data,
  output logic       printable
);

  assign printable = (data >= CHAR_LO) && (data <= CHAR_HI);

endmodule

// File: rtl/pt_check.sv
// Scans a length-prefixed message in plaintext memory and flags whether every byte is printable.
// Optional macro PT_CHECK_BADIDX_EN adds the bad_idx output (index of the first offending byte).
module pt_check
  import pt_check_pkg::*;
#(
  parameter logic [7:0] CHAR_LO = CHAR_LO_DEF,
  parameter logic [7:0] CHAR_HI = CHAR_HI_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata,
  output logic       valid
`ifdef PT_CHECK_BADIDX_EN
  ,
  output logic [7:0] bad_idx
`endif
);

  state_t     state;
  logic [7:0] len;
  logic [8:0] idx;   // 9 bits so i=255 compares cleanly against L
  logic       byte_ok;
  logic       scan_last;
  logic       scan_more;

  pt_is_printable #(
    .CHAR_LO (CHAR_LO),
    .CHAR_HI (CHAR_HI)
  ) u_prn (
    .data      (pt_rddata),
    .printable (byte_ok)
  );

  assign rdy       = (state == IDLE);
  assign scan_last = (idx == {1'b0, len});
  // Only prefetch a further byte while one remains; the address never passes L.
  assign scan_more = ((idx + 9'd1) < {1'b0, len});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      pt_addr <= 8'd0;
      valid   <= 1'b0;
      len     <= 8'd0;
      idx     <= 9'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (en) begin
            state   <= FETCH_LEN;
            valid   <= 1'b0;
            pt_addr <= 8'd0;
          end
        end
        FETCH_LEN: begin
          state   <= LEN;
          pt_addr <= 8'd1;
        end
        LEN: begin
          len <= pt_rddata;
          if (pt_rddata == 8'd0) begin
            state   <= IDLE;
            valid   <= 1'b1;
            pt_addr <= 8'd0;
          end else begin
            state   <= SCAN;
            idx     <= 9'd1;
            pt_addr <= (pt_rddata > 8'd1) ? 8'd2 : 8'd1;
          end
        end
        SCAN: begin
          if (!byte_ok) begin
            state   <= IDLE;
            valid   <= 1'b0;
            pt_addr <= 8'd0;
          end else if (scan_last) begin
            state   <= IDLE;
            valid   <= 1'b1;
            pt_addr <= 8'd0;
          end else begin
            idx <= idx + 9'd1;
            if (scan_more) pt_addr <= idx[7:0] + 8'd2;
          end
        end
      endcase
    end
  end

`ifdef PT_CHECK_BADIDX_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bad_idx <= 8'd0;
    end else if (state == LEN && pt_rddata == 8'd0) begin
      bad_idx <= 8'd0;
    end else if (state == SCAN) begin
      if (!byte_ok)       bad_idx <= idx[7:0];
      else if (scan_last) bad_idx <= 8'd0;
    end
  end
`endif

endmodule

// File: tb/tb_pt_check.sv
// Directed bench for pt_check: length-prefixed messages, latency, early abort, L=255, busy en, mid-scan reset.
module tb_pt_check;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       rdy;
  logic [7:0] pt_addr;
  logic [7:0] pt_rddata;
  logic       valid;
`ifdef PT_CHECK_BADIDX_EN
  logic [7:0] bad_idx;
`endif

  logic [7:0] mem [256];
  logic [7:0] addr_q [$];
  int nchk = 0;
  int nerr = 0;
  int busy;

  pt_check dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rdy       (rdy),
    .pt_addr   (pt_addr),
    .pt_rddata (pt_rddata),
    .valid     (valid)
`ifdef PT_CHECK_BADIDX_EN
    ,
    .bad_idx   (bad_idx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1-cycle read latency memory
  always @(posedge clk) pt_rddata <= mem[pt_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
  endtask

  // Pulse (or hold) en and count the cycles rdy stays low, logging pt_addr each busy cycle.
  task automatic run(input bit hold, output int n);
    addr_q.delete();
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    if (!hold) en = 1'b0;
    n = 0;
    while (!rdy && n < 400) begin
      addr_q.push_back(pt_addr);
      n++;
      @(negedge clk);
    end
    en = 1'b0;
    if (n >= 400) check("run_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_bad(input string tag, input logic [7:0] exp);
`ifdef PT_CHECK_BADIDX_EN
    check(tag, {24'd0, bad_idx}, {24'd0, exp});
`endif
  endtask

  function automatic bit addr_seen(input logic [7:0] a);
    foreach (addr_q[i]) if (addr_q[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    clear_mem();
    repeat (3) @(negedge clk);
    check("rst_rdy", {31'd0, rdy}, 32'd1);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_addr", {24'd0, pt_addr}, 32'd0);
    check_bad("rst_bad_idx", 8'd0);
    rst_n = 1'b1;

    // {3,'a','b','c'}
    clear_mem();
    mem[0] = 8'd3; mem[1] = "a"; mem[2] = "b"; mem[3] = "c";
    run(1'b0, busy);
    check("abc_busy", busy, 32'd5);
    check("abc_valid", {31'd0, valid}, 32'd1);
    check("abc_nq", addr_q.size(), 32'd5);
    for (int i = 0; i < 4; i++)
      if (i < addr_q.size()) check($sformatf("abc_addr%0d", i), {24'd0, addr_q[i]}, i);
    check_bad("abc_bad_idx", 8'd0);

    // {4,'H',0x0A,'i','!'} aborts at index 2
    clear_mem();
    mem[0] = 8'd4; mem[1] = "H"; mem[2] = 8'h0A; mem[3] = "i"; mem[4] = "!";
    run(1'b0, busy);
    check("abort_busy", busy, 32'd4);
    check("abort_valid", {31'd0, valid}, 32'd0);
    check("abort_no_addr4", {31'd0, addr_seen(8'd4)}, 32'd0);
    check_bad("abort_bad_idx", 8'd2);

    // empty message
    clear_mem();
    mem[0] = 8'd0;
    run(1'b0, busy);
    check("empty_busy", busy, 32'd2);
    check("empty_valid", {31'd0, valid}, 32'd1);
    check_bad("empty_bad_idx", 8'd0);

    // L=255 of 0x7E; byte 0 (0xFF) would fail if ever consumed as data
    clear_mem();
    mem[0] = 8'd255;
    for (int i = 1; i < 256; i++) mem[i] = 8'h7E;
    run(1'b0, busy);
    check("max_busy", busy, 32'd257);
    check("max_valid", {31'd0, valid}, 32'd1);
    check_bad("max_bad_idx", 8'd0);
    mem[1] = 8'h7F;
    run(1'b0, busy);
    check("max7f_busy", busy, 32'd3);
    check("max7f_valid", {31'd0, valid}, 32'd0);
    check_bad("max7f_bad_idx", 8'd1);

    // low boundary: 0x20 accepted, 0x1F rejected
    clear_mem();
    mem[0] = 8'd2; mem[1] = 8'h20; mem[2] = 8'h1F;
    run(1'b0, busy);
    check("lo_busy", busy, 32'd4);
    check("lo_valid", {31'd0, valid}, 32'd0);
    check_bad("lo_bad_idx", 8'd2);
    mem[0] = 8'd1;
    run(1'b0, busy);
    check("lo1_busy", busy, 32'd3);
    check("lo1_valid", {31'd0, valid}, 32'd1);

    // en held high throughout the scan
    clear_mem();
    mem[0] = 8'd3; mem[1] = "a"; mem[2] = "b"; mem[3] = "c";
    run(1'b1, busy);
    check("hold_busy", busy, 32'd5);
    check("hold_valid", {31'd0, valid}, 32'd1);
    @(negedge clk);
    check("hold_stay_idle", {31'd0, rdy}, 32'd1);

    // reset mid-scan
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    check("accept_clears_valid", {31'd0, valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("midscan_busy", {31'd0, rdy}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_rdy", {31'd0, rdy}, 32'd1);
    check("midrst_valid", {31'd0, valid}, 32'd0);
    check("midrst_addr", {24'd0, pt_addr}, 32'd0);
    rst_n = 1'b1;
    run(1'b0, busy);
    check("post_rst_busy", busy, 32'd5);
    check("post_rst_valid", {31'd0, valid}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
